// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output reorder buffer.
// Bank states, default frame length and the bit-reverse index function.
package fft_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } bank_state_t;

  localparam int N_POINTS_DFLT = 32;

  function automatic logic [31:0] bitrev(
    input logic [31:0] idx,
    input int          nbits
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < nbits) r[nbits-1-i] = idx[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One N-entry register bank with two write ports and two
// combinational read ports; the two write addresses are always distinct.
module fft_reorder_bank #(
  parameter int W = 16,
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [$clog2(N)-1:0] wa0,
  input  logic [W-1:0]         wd0,
  input  logic [$clog2(N)-1:0] wa1,
  input  logic [W-1:0]         wd1,
  input  logic [$clog2(N)-1:0] ra0,
  input  logic [$clog2(N)-1:0] ra1,
  output logic [W-1:0]         rd0,
  output logic [W-1:0]         rd1
);

  logic [W-1:0] mem_q [N];
  logic [W-1:0] mem_d [N];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[wa0] = wd0;
      mem_d[wa1] = wd1;
    end
  end

  // Sample storage carries no reset; its contents are only
  // observed once a bank has been completely written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd0 = mem_q[ra0];
  assign rd1 = mem_q[ra1];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed pairs in, natural-order pairs out.
// Optional out_index port when FFT_REORDER_INDEX_EN is defined.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_POINTS   = N_POINTS_DFLT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       x0,
  input  logic [DATA_WIDTH-1:0]       x1,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [DATA_WIDTH-1:0]       y0,
  output logic [DATA_WIDTH-1:0]       y1,
  output logic                        out_sop,
  output logic                        out_eop,
`ifdef FFT_REORDER_INDEX_EN
  output logic [$clog2(N_POINTS)-1:0] out_index,
`endif
  output logic                        overflow
);

  localparam int AW = $clog2(N_POINTS);
  localparam int CW = AW - 1;
  localparam logic [CW-1:0] LAST = CW'(N_POINTS / 2 - 1);

  bank_state_t st_q [2];
  bank_state_t st_d [2];
  logic        w_bank_q, w_bank_d;
  logic        r_bank_q, r_bank_d;
  logic [CW-1:0] w_cnt_q, w_cnt_d;
  logic [CW-1:0] r_cnt_q, r_cnt_d;
  logic        drop_q, drop_d;
  logic        ovf_q, ovf_d;

  logic        cur_drop;
  logic        we;
  logic [AW-1:0] wa0, wa1, ra0, ra1;
  logic [DATA_WIDTH-1:0] rd0 [2];
  logic [DATA_WIDTH-1:0] rd1 [2];

  assign out_valid = (st_q[r_bank_q] == FULL);

  always_comb begin
    st_d     = st_q;
    w_bank_d = w_bank_q;
    r_bank_d = r_bank_q;
    w_cnt_d  = w_cnt_q;
    r_cnt_d  = r_cnt_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    cur_drop = drop_q;
    we       = 1'b0;
    // Frame admission looks at registered state only, so a bank
    // freed on this same edge still counts as busy.
    if (in_valid) begin
      if (w_cnt_q == '0) begin
        if (st_q[w_bank_q] == EMPTY) begin
          cur_drop         = 1'b0;
          st_d[w_bank_q]   = FILLING;
        end else begin
          cur_drop = 1'b1;
          ovf_d    = 1'b1;
        end
      end
      we = !cur_drop;
      if (w_cnt_q == LAST) begin
        w_cnt_d = '0;
        drop_d  = 1'b0;
        if (!cur_drop) begin
          st_d[w_bank_q] = FULL;
          w_bank_d       = !w_bank_q;
        end
      end else begin
        w_cnt_d = w_cnt_q + 1'b1;
        drop_d  = cur_drop;
      end
    end
    if (out_valid && out_ready) begin
      if (r_cnt_q == LAST) begin
        r_cnt_d        = '0;
        st_d[r_bank_q] = EMPTY;
        r_bank_d       = !r_bank_q;
      end else begin
        r_cnt_d = r_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q[0]  <= EMPTY;
      st_q[1]  <= EMPTY;
      w_bank_q <= 1'b0;
      r_bank_q <= 1'b0;
      w_cnt_q  <= '0;
      r_cnt_q  <= '0;
      drop_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      w_bank_q <= w_bank_d;
      r_bank_q <= r_bank_d;
      w_cnt_q  <= w_cnt_d;
      r_cnt_q  <= r_cnt_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  assign wa0 = AW'(bitrev(32'({w_cnt_q, 1'b0}), AW));
  assign wa1 = AW'(bitrev(32'({w_cnt_q, 1'b1}), AW));
  assign ra0 = {r_cnt_q, 1'b0};
  assign ra1 = {r_cnt_q, 1'b1};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_reorder_bank #(
      .W (DATA_WIDTH),
      .N (N_POINTS)
    ) u_bank (
      .clk (clk),
      .we  (we && (w_bank_q == 1'(b))),
      .wa0 (wa0),
      .wd0 (x0),
      .wa1 (wa1),
      .wd1 (x1),
      .ra0 (ra0),
      .ra1 (ra1),
      .rd0 (rd0[b]),
      .rd1 (rd1[b])
    );
  end

  assign y0       = rd0[r_bank_q];
  assign y1       = rd1[r_bank_q];
  assign out_sop  = out_valid && (r_cnt_q == '0);
  assign out_eop  = out_valid && (r_cnt_q == LAST);
  assign overflow = ovf_q;

`ifdef FFT_REORDER_INDEX_EN
  assign out_index = {r_cnt_q, 1'b0};
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder (N=32, 16-bit samples).
// Expected pairs come from a queue filled with hand-derived bin values.
module tb_fft_bitrev_reorder;

  localparam int W = 16;
  localparam int N = 32;
  localparam int H = N / 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] x0 = '0;
  logic [W-1:0] x1 = '0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [W-1:0] y0;
  logic [W-1:0] y1;
  logic         out_sop;
  logic         out_eop;
  logic         overflow;
`ifdef FFT_REORDER_INDEX_EN
  logic [4:0]   out_index;
`endif

  fft_bitrev_reorder #(
    .DATA_WIDTH (W),
    .N_POINTS   (N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .x0        (x0),
    .x1        (x1),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .y0        (y0),
    .y1        (y1),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
`ifdef FFT_REORDER_INDEX_EN
    .out_index (out_index),
`endif
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int y0;
    int y1;
    bit sop;
    bit eop;
    int k;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int br5(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 5; i++) begin
      if (v[i]) r = r | (1 << (4 - i));
    end
    return r;
  endfunction

  task automatic push_frame(input int f);
    for (int k = 0; k < H; k++) begin
      q.push_back('{f*32 + 2*k, f*32 + 2*k + 1, k == 0, k == H-1, k});
    end
  endtask

  task automatic send_pair(input int f, input int j);
    in_valid = 1'b1;
    x0 = W'(f*32 + br5(2*j));
    x1 = W'(f*32 + br5(2*j + 1));
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int f, input bit gaps);
    for (int j = 0; j < H; j++) begin
      send_pair(f, j);
      if (gaps && (j % 2 == 0)) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    for (int c = 0; c < 3000 && q.size() != 0; c++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    check("drain_left", q.size(), 0);
    out_ready = 1'b1;
  endtask

  logic [W-1:0] h_y0, h_y1;
  logic         h_sop, h_eop;
  bit           h_pend = 1'b0;

  // Scoreboard plus hold check while the consumer stalls.
  always @(negedge clk) begin
    if (!reset) begin
      h_pend = 1'b0;
    end else begin
      if (h_pend && out_valid) begin
        check("hold_y0", y0, h_y0);
        check("hold_y1", y1, h_y1);
        check("hold_sop", out_sop, h_sop);
        check("hold_eop", out_eop, h_eop);
      end
      h_pend = 1'b0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("extra_pair", 32'(out_valid), 0);
        end else begin
          mon_e = q.pop_front();
          check("y0", y0, mon_e.y0);
          check("y1", y1, mon_e.y1);
          check("sop", out_sop, mon_e.sop);
          check("eop", out_eop, mon_e.eop);
`ifdef FFT_REORDER_INDEX_EN
          check("index", out_index, 2 * mon_e.k);
`endif
        end
      end else if (out_valid) begin
        h_pend = 1'b1;
        h_y0   = y0;
        h_y1   = y1;
        h_sop  = out_sop;
        h_eop  = out_eop;
      end
    end
  end

  initial begin
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_sop", out_sop, 0);
    check("rst_eop", out_eop, 0);
    check("rst_ovf", overflow, 0);
`ifdef FFT_REORDER_INDEX_EN
    check("rst_index", out_index, 0);
`endif
    reset = 1'b1;
    @(posedge clk);
    #1;

    // single frame, latency of one cycle after the last pair
    out_ready = 1'b1;
    push_frame(0);
    for (int j = 0; j < H - 1; j++) send_pair(0, j);
    check("t1_pre_valid", out_valid, 0);
    send_pair(0, H - 1);
    in_valid = 1'b0;
    check("t1_lat_valid", out_valid, 1);
    check("t1_lat_sop", out_sop, 1);
    drain(1'b0);
    check("t1_idle", out_valid, 0);

    // four back-to-back frames with the consumer always ready
    for (int f = 1; f <= 4; f++) push_frame(f);
    for (int f = 1; f <= 4; f++) send_frame(f, 1'b0);
    drain(1'b0);
    check("t2_ovf", overflow, 0);

    // stalled consumer: third frame must be dropped
    out_ready = 1'b0;
    push_frame(5);
    push_frame(6);
    send_frame(5, 1'b0);
    send_frame(6, 1'b0);
    send_frame(7, 1'b0);
    check("t3_ovf", overflow, 1);
    check("t3_valid", out_valid, 1);
    out_ready = 1'b1;
    drain(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t3_empty", out_valid, 0);

    // input gaps and random consumer stalls
    out_ready = 1'b0;
    push_frame(0);
    send_frame(0, 1'b1);
    drain(1'b1);

    // reset in the middle of a fill while the other bank drains
    out_ready = 1'b0;
    push_frame(9);
    send_frame(9, 1'b0);
    for (int j = 0; j < 7; j++) begin
      out_ready = (j >= 2);
      send_pair(10, j);
    end
    check("t5_pre_left", q.size(), H - 5);
    x0 = W'(10*32 + br5(14));
    x1 = W'(10*32 + br5(15));
    reset = 1'b0;
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_sop", out_sop, 0);
    check("t5_rst_eop", out_eop, 0);
    check("t5_rst_ovf", overflow, 0);
    q.delete();
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_stale", out_valid, 0);
    out_ready = 1'b1;
    push_frame(0);
    send_frame(0, 1'b0);
    check("t5_lat_valid", out_valid, 1);
    drain(1'b0);
    check("t5_idle", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
